decoder3to8_stream: RTL and testbench

- Registered 3-to-8 one-hot decoder with valid/ready handshakes on both sides.
- Inverse of the 8-to-3 encoder: consumes 3-bit codes and produces 8-bit one-hot words.
- A 2-entry skid buffer gives full throughput with registered in_ready.
- A wrapping counter reports how many words have been delivered.

---
 rtl/decoder3to8_stream.sv | 97 +++++++++
 tb/tb_decoder3to8_stream.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/decoder3to8_stream.sv
// Registered 3-to-8 one-hot decoder with valid/ready on both sides, a 2-entry skid buffer
// and a wrapping delivered-word counter. Define DECODER3TO8_HOLD_EN to keep the last word on out_onehot while idle.
module decoder3to8_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       main_q, main_d;
    logic [7:0]       skid_q, skid_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] count_q;
    logic             in_fire, out_fire;
    logic [7:0]       word;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;
    assign word      = 8'b0000_0001 << in_code;
    assign count     = count_q;

`ifdef DECODER3TO8_HOLD_EN
    // main is never cleared on drain, so it still holds the last delivered word
    assign out_onehot = main_q;
`else
    assign out_onehot = out_valid ? main_q : 8'h00;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = word;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = word;
                end else if (in_fire) begin
                    state_d = TWO;
                    skid_d  = word;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // in_ready is registered from the next state so it never depends on this cycle's inputs
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= 8'h00;
            skid_q     <= 8'h00;
            in_ready_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != TWO);
            if (out_fire) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decoder3to8_stream.sv
// Directed self-checking bench for decoder3to8_stream (CNT_W=4 so the counter wraps quickly).
module tb_decoder3to8_stream;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       in_code;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_onehot;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count = 0;
    logic [7:0] idle_word;

    decoder3to8_stream #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_code    (in_code),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // advance one rising edge, return at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_expect(input string tag, input logic [7:0] last);
`ifdef DECODER3TO8_HOLD_EN
        check(tag, {24'h0, out_onehot}, {24'h0, last});
`else
        check(tag, {24'h0, out_onehot}, 32'h0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_code = 3'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_onehot", out_onehot, 0);
        check("rst_count", count, 0);
        rst_n = 1'b1;
        step();
        check("rel_in_ready", in_ready, 1);

        // sweep 0..7 at full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_code = 3'(i);
            step();
            check($sformatf("sweep_word%0d", i), out_onehot, 32'h1 << i);
            check($sformatf("sweep_valid%0d", i), out_valid, 1);
            check($sformatf("sweep_ready%0d", i), in_ready, 1);
            check($sformatf("sweep_count%0d", i), count, i);
        end
        in_valid = 1'b0; in_code = 3'bxxx;
        step();
        exp_count = 8;
        check("sweep_count", count, exp_count);
        check("sweep_idle_valid", out_valid, 0);
        idle_expect("sweep_idle_word", 8'h80);
        step();
        idle_expect("x_code_idle_word", 8'h80);

        // backpressure: fill both entries, third code must wait
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd3;
        step();
        in_code = 3'd5;
        step();
        check("bp_in_ready", in_ready, 0);
        check("bp_word", out_onehot, 8'h08);
        in_code = 3'd7;
        step();
        check("bp_stable_word", out_onehot, 8'h08);
        check("bp_still_full", in_ready, 0);
        check("bp_count_held", count, exp_count);
        out_ready = 1'b1;
        step();
        check("bp_drain1", out_onehot, 8'h20);
        check("bp_reopen", in_ready, 1);
        step();
        check("bp_drain2", out_onehot, 8'h80);
        in_valid = 1'b0;
        step();
        exp_count += 3;
        check("bp_count", count, exp_count);
        check("bp_empty", out_valid, 0);

        // simultaneous accept and deliver while in ONE
        out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd1;
        step();
        check("sim_before", out_onehot, 8'h02);
        out_ready = 1'b1; in_code = 3'd6;
        step();
        exp_count += 1;
        check("sim_word", out_onehot, 8'h40);
        check("sim_valid", out_valid, 1);
        check("sim_in_ready", in_ready, 1);
        check("sim_count", count, exp_count);
        in_valid = 1'b0;
        step();
        exp_count += 1;
        idle_expect("sim_idle_word", 8'h40);

        // wrap: 13 delivered so far, 4 more makes 17 -> 1
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_code = 3'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        exp_count += 4;
        check("wrap_count", count, exp_count % 16);
        check("wrap_count_is1", count, 1);

        // reset mid-stream with two words buffered
        out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd2;
        step();
        in_code = 3'd4;
        step();
        check("pre_rst_full", in_ready, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_word", out_onehot, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        check("post_rst_discarded", out_valid, 0);
        check("post_rst_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
